// File: rtl/ring_osc_meas_ctrl.sv
// ring_osc_meas_ctrl
// Sequencer and frequency counter for the on-die ring oscillator.
// On an accepted start it enables the oscillator, lets it run for a fixed
// warm-up window, then counts rising edges of one selected oscillator tap
// over a programmable gate of clk cycles. Afterwards it switches the
// oscillator off and reports the count with a one-cycle done strobe.
//
// Ports:
//   clk          system clock
//   rst_n        synchronous active-low reset
//   ena          design enable, low aborts to IDLE
//   start        measurement request (sampled only in IDLE)
//   long_ring    ring length select (sampled with start)
//   tap_sel      tap select 0..3 (sampled with start)
//   gate_cycles  gate length in clk cycles (sampled with start)
//   osc_tap      asynchronous oscillator taps n1..n4
//   osc_en0      oscillator enable
//   osc_en1      long-ring stage enable
//   busy         high during WARMUP and GATE
//   done         one-cycle strobe, count valid
//   count        edge count of the last measurement
//   overflow     counter saturated during the last measurement
//
// Optional feature macro: RO_PRESCALE_EN
//   When defined, the selected tap is divided by two in its own clock
//   domain before synchronization, so count reports half the tap edges.
module ring_osc_meas_ctrl #(
  parameter int CNT_W       = 16,
  parameter int GATE_W      = 12,
  parameter int WARM_CYC    = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              start,
  input  logic              long_ring,
  input  logic [1:0]        tap_sel,
  input  logic [GATE_W-1:0] gate_cycles,
  input  logic [3:0]        osc_tap,
  output logic              osc_en0,
  output logic              osc_en1,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  count,
  output logic              overflow
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WARM = 2'd1;
  localparam logic [1:0] ST_GATE = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [GATE_W-1:0] GATE_ZERO = {GATE_W{1'b0}};
  localparam logic [GATE_W-1:0] GATE_ONE  = GATE_W'(1);
  localparam logic [GATE_W-1:0] WARM_LAST = GATE_W'(WARM_CYC - 1);
  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  logic [1:0]             state_q, state_d;
  logic [1:0]             tap_sel_q, tap_sel_d;
  logic                   long_q, long_d;
  logic [GATE_W-1:0]      gate_q, gate_d;
  logic [GATE_W-1:0]      timer_q, timer_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   ovf_q, ovf_d;
  logic                   en0_q, en0_d;
  logic                   en1_q, en1_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   sel_tap_s;
  logic                   sync_in_s;
  logic                   edge_s;
  logic                   run_s;

  // The latched selection is used, so later tap_sel changes have no effect.
  assign sel_tap_s = osc_tap[tap_sel_q];

`ifdef RO_PRESCALE_EN
  logic div_q;

  // Divide-by-2 toggle in the tap domain, held clear while the oscillator is off.
  always_ff @(posedge sel_tap_s or negedge en0_q) begin
    if (!en0_q) begin
      div_q <= 1'b0;
    end else begin
      div_q <= ~div_q;
    end
  end

  assign sync_in_s = div_q;
`else
  assign sync_in_s = sel_tap_s;
`endif

  // Synchronizer plus previous-value flop; runs in every state so the
  // chain has settled before GATE and no spurious edge is counted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{1'b0}};
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sync_in_s};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_s = sync_q[SYNC_STAGES-1] & ~prev_q;

  // Next-state, timer and counter logic.
  always_comb begin
    state_d   = state_q;
    tap_sel_d = tap_sel_q;
    long_d    = long_q;
    gate_d    = gate_q;
    timer_d   = timer_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    if (!ena) begin
      // Abort: partial count and overflow are kept.
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d   = ST_WARM;
            tap_sel_d = tap_sel;
            long_d    = long_ring;
            gate_d    = gate_cycles;
            timer_d   = WARM_LAST;
            count_d   = CNT_ZERO;
            ovf_d     = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_WARM: begin
          if (timer_q == GATE_ZERO) begin
            // A zero-length gate goes straight to DONE.
            if (gate_q == GATE_ZERO) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_GATE;
              timer_d = gate_q - GATE_ONE;
            end
          end else begin
            timer_d = timer_q - GATE_ONE;
          end
        end
        ST_GATE: begin
          if (edge_s) begin
            // Saturate at all-ones; any further edge flags overflow.
            if (count_q == CNT_MAX) begin
              ovf_d = 1'b1;
            end else begin
              count_d = count_q + CNT_ONE;
            end
          end else begin
            count_d = count_q;
          end
          if (timer_q == GATE_ZERO) begin
            state_d = ST_DONE;
          end else begin
            timer_d = timer_q - GATE_ONE;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Outputs are derived from the next state so they are registered and
  // line up with the state they describe.
  always_comb begin
    run_s  = (state_d == ST_WARM) || (state_d == ST_GATE);
    en0_d  = run_s;
    en1_d  = run_s & long_d;
    busy_d = run_s;
    done_d = (state_d == ST_DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      tap_sel_q <= 2'd0;
      long_q    <= 1'b0;
      gate_q    <= GATE_ZERO;
      timer_q   <= GATE_ZERO;
      count_q   <= CNT_ZERO;
      ovf_q     <= 1'b0;
      en0_q     <= 1'b0;
      en1_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tap_sel_q <= tap_sel_d;
      long_q    <= long_d;
      gate_q    <= gate_d;
      timer_q   <= timer_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      en0_q     <= en0_d;
      en1_q     <= en1_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign osc_en0  = en0_q;
  assign osc_en1  = en1_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign count    = count_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_ring_osc_meas_ctrl.sv
// Self-checking bench for ring_osc_meas_ctrl: table vectors, random runs
// against a gate/period model, and hand sequences for reset, saturation,
// abort and restart corner cases.
module tb_ring_osc_meas_ctrl;
  localparam int WARM = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b0;
  logic        start = 1'b0;
  logic        long_ring = 1'b0;
  logic [1:0]  tap_sel = 2'd0;
  logic [11:0] gate_cycles = 12'd0;
  logic [3:0]  osc_tap = 4'b0000;

  logic        osc_en0, osc_en1, busy, done, overflow;
  logic [15:0] count;
  logic        s_osc_en0, s_osc_en1, s_busy, s_done, s_overflow;
  logic [3:0]  s_count;

  int checks = 0;
  int errors = 0;
  int hp[4]   = '{2, 2, 2, 2};
  int tcnt[4] = '{0, 0, 0, 0};

  typedef struct {
    logic [1:0] sel;
    logic       lr;
    int         g;
    int         h;
    int         exp_c;
    int         tol;
    bit         poke;
  } vec_t;

  vec_t tbl[6];

  ring_osc_meas_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start),
    .long_ring(long_ring), .tap_sel(tap_sel), .gate_cycles(gate_cycles),
    .osc_tap(osc_tap), .osc_en0(osc_en0), .osc_en1(osc_en1),
    .busy(busy), .done(done), .count(count), .overflow(overflow)
  );

  ring_osc_meas_ctrl #(.CNT_W(4)) u_small (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start),
    .long_ring(long_ring), .tap_sel(tap_sel), .gate_cycles(gate_cycles),
    .osc_tap(osc_tap), .osc_en0(s_osc_en0), .osc_en1(s_osc_en1),
    .busy(s_busy), .done(s_done), .count(s_count), .overflow(s_overflow)
  );

  always #5 clk = ~clk;

  // Oscillator tap model: tap i toggles every hp[i] clk cycles.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (tcnt[i] + 1 >= hp[i]) begin
        osc_tap[i] <= ~osc_tap[i];
        tcnt[i] <= 0;
      end else begin
        tcnt[i] <= tcnt[i] + 1;
      end
    end
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_rng(input string nm, input longint act, input longint lo, input longint hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d..%0d at %0t", nm, act, lo, hi, $time);
    end
  endtask

  // One measurement: start at edge t, then check every following cycle k.
  task automatic run_meas(input logic [1:0] sel, input logic lr, input int g,
                          input int h, input int exp_c, input int tol, input bit poke);
    int lat = 1 + WARM + g;
    int ndone = 0;
    logic act;
    for (int i = 0; i < 4; i++) hp[i] = (i == sel) ? h : $urandom_range(1, 8);
    repeat (10) @(negedge clk);
    tap_sel = sel; long_ring = lr; gate_cycles = 12'(g); ena = 1'b1; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    // Changes after acceptance must not affect the measurement.
    tap_sel = 2'($urandom); gate_cycles = 12'($urandom); long_ring = 1'($urandom);
    for (int k = 1; k <= lat + 3; k++) begin
      @(negedge clk);
      act = (k <= lat - 1);
      chk("busy", busy, act);
      chk("osc_en0", osc_en0, act);
      chk("osc_en1", osc_en1, act & lr);
      chk("done", done, (k == lat));
      if (done) ndone++;
      if (k == 1) begin
        chk("count_clear", count, 0);
        chk("ovf_clear", overflow, 0);
        chk("s_count_clear", s_count, 0);
        chk("s_ovf_clear", s_overflow, 0);
      end
      if (k == lat) begin
        chk_rng("count", count, (exp_c - tol < 0) ? 0 : exp_c - tol, exp_c + tol);
        chk("overflow", overflow, 0);
      end
      if (poke) start = ((k >= 2) && (k <= lat) && (k % 3 == 0)) || (k == lat);
      else start = 1'b0;
    end
    start = 1'b0;
    chk("done_pulses", ndone, 1);
  endtask

  initial begin
    tbl[0] = '{2'd2, 1'b0, 60, 3, 10, 1, 1'b0};
    tbl[1] = '{2'd0, 1'b1, 0, 2, 0, 0, 1'b0};
    tbl[2] = '{2'd1, 1'b1, 1, 1, 0, 1, 1'b0};
    tbl[3] = '{2'd3, 1'b0, 100, 5, 10, 1, 1'b0};
    tbl[4] = '{2'd2, 1'b1, 40, 1, 20, 1, 1'b0};
    tbl[5] = '{2'd1, 1'b0, 30, 2, 7, 1, 1'b1};

    // Reset with start held high: everything stays low.
    rst_n = 1'b0; ena = 1'b1; start = 1'b1; gate_cycles = 12'd5; tap_sel = 2'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_en0", osc_en0, 0);
      chk("rst_en1", osc_en1, 0);
      chk("rst_done", done, 0);
      chk("rst_count", count, 0);
      chk("rst_ovf", overflow, 0);
    end
    rst_n = 1'b1;
    // Start still high: accepted at the first edge after release, and
    // relaunched on the first IDLE cycle after DONE.
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      chk("rel_busy", busy, (k <= 9) || (k == 12));
      chk("rel_done", done, (k == 10));
    end
    ena = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("rel_abort_busy", busy, 0);
    chk("rel_abort_en0", osc_en0, 0);
    ena = 1'b1;

    // Table vectors.
    for (int i = 0; i < 6; i++) begin
      run_meas(tbl[i].sel, tbl[i].lr, tbl[i].g, tbl[i].h, tbl[i].exp_c, tbl[i].tol, tbl[i].poke);
    end

    // Saturation on the 4-bit instance, then the next start clears it.
    run_meas(2'd1, 1'b0, 200, 2, 50, 1, 1'b0);
    chk("sat_count", s_count, 15);
    chk("sat_ovf", s_overflow, 1);
    run_meas(2'd0, 1'b0, 16, 4, 2, 1, 1'b0);
    chk_rng("unsat_count", s_count, 1, 3);
    chk("unsat_ovf", s_overflow, 0);

    // Abort 10 cycles into GATE.
    begin
      int nd = 0;
      for (int i = 0; i < 4; i++) hp[i] = 2;
      repeat (5) @(negedge clk);
      tap_sel = 2'd3; long_ring = 1'b1; gate_cycles = 12'd100; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int k = 1; k <= 15; k++) begin
        @(negedge clk);
        chk("abort_busy", busy, 1);
      end
      ena = 1'b0;
      @(negedge clk);
      chk("abort_busy_off", busy, 0);
      chk("abort_en0_off", osc_en0, 0);
      chk("abort_en1_off", osc_en1, 0);
      chk_rng("abort_partial", count, 1, 4);
      for (int k = 0; k < 120; k++) begin
        @(negedge clk);
        if (done) nd++;
      end
      chk("abort_no_done", nd, 0);
      ena = 1'b1;
      run_meas(2'd2, 1'b0, 60, 3, 10, 1, 1'b0);
    end

    // Randomized runs against the gate/period model.
    for (int r = 0; r < 20; r++) begin
      int g = $urandom_range(0, 150);
      int h = $urandom_range(1, 8);
      run_meas(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), g, h,
               g / (2 * h), 1, ($urandom_range(0, 3) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
